// File: rtl/wb_mem_pkg.sv
// Shared types and constants for the Wishbone data memory slice.
package wb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Wide enough for READ_WAIT up to 15.
  localparam int CNT_W = 4;

  function automatic int lanes_of(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/wb_mem_array.sv
// Single-port word array with byte-lane write enables; the registered read
// port returns the post-write (merged) word on write cycles.
module wb_mem_array
  import wb_mem_pkg::*;
#(
  parameter int DW    = 8,
  parameter int AW    = 8,
  parameter int DEPTH = 256,
  parameter int SW    = lanes_of(DW)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [SW-1:0] sel_i,
  input  logic [AW-1:0] adr_i,
  input  logic [DW-1:0] dat_i,
  output logic [DW-1:0] dat_o
);

  logic [DW-1:0] mem_r [DEPTH];
  logic [DW-1:0] merged_s;
  logic [DW-1:0] rd_r;

  // Merge selected write lanes over the stored word.
  always_comb begin
    merged_s = mem_r[adr_i];
    for (int i = 0; i < SW; i++) begin
      merged_s[8*i +: 8] = (we_i && sel_i[i]) ? dat_i[8*i +: 8] : mem_r[adr_i][8*i +: 8];
    end
  end

  // Array storage; contents deliberately have no reset.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem_r[adr_i] <= merged_s;
    end
  end

  // Read register holds its value whenever the array is not accessed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_r <= '0;
    end else if (en_i) begin
      rd_r <= merged_s;
    end
  end

  assign dat_o = rd_r;

endmodule

// File: rtl/wb_data_mem.sv
// Wishbone-classic slave data memory: range check, read wait states and
// registered ack/err responses driven by a three-state control FSM.
module wb_data_mem
  import wb_mem_pkg::*;
#(
  parameter int DW        = 8,
  parameter int AW        = 8,
  parameter int DEPTH     = 256,
  parameter int READ_WAIT = 0,
  parameter int SW        = lanes_of(DW)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cyc_i,
  input  logic          stb_i,
  input  logic          we_i,
  input  logic [SW-1:0] sel_i,
  input  logic [AW-1:0] adr_i,
  input  logic [DW-1:0] dat_i,
  output logic [DW-1:0] dat_o,
  output logic          ack_o,
  output logic          err_o
);

  localparam logic [AW:0]      DEPTH_L   = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] WAIT_INIT = (READ_WAIT > 0) ? CNT_W'(READ_WAIT - 1) : CNT_W'(0);

  state_e           state_r, state_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic [AW-1:0]    adr_r, adr_n;
  logic             ack_r, ack_n;
  logic             err_r, err_n;
  logic             in_range_s;
  logic             mem_en_s;
  logic             mem_we_s;
  logic [AW-1:0]    mem_adr_s;

  assign in_range_s = ({1'b0, adr_i} < DEPTH_L);

  // Next-state, array strobes and response decode.
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    adr_n     = adr_r;
    ack_n     = 1'b0;
    err_n     = 1'b0;
    mem_en_s  = 1'b0;
    mem_we_s  = 1'b0;
    mem_adr_s = adr_i;
    case (state_r)
      IDLE: begin
        if (cyc_i && stb_i) begin
          adr_n = adr_i;
          if (!in_range_s) begin
            state_n = RESP;
            err_n   = 1'b1;
          end else if (we_i || (READ_WAIT == 0)) begin
            mem_en_s = 1'b1;
            mem_we_s = we_i;
            state_n  = RESP;
            ack_n    = 1'b1;
          end else begin
            cnt_n   = WAIT_INIT;
            state_n = WAIT;
          end
        end else begin
          state_n = IDLE;
        end
      end
      WAIT: begin
        mem_adr_s = adr_r;
        if (!cyc_i) begin
          state_n = IDLE;
        end else if (cnt_r == CNT_ZERO) begin
          mem_en_s = 1'b1;
          state_n  = RESP;
          ack_n    = 1'b1;
        end else begin
          cnt_n = cnt_r - CNT_ONE;
        end
      end
      RESP: begin
        // Inputs are ignored here so a lingering strobe is not re-accepted.
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      adr_r   <= '0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      adr_r   <= adr_n;
      ack_r   <= ack_n;
      err_r   <= err_n;
    end
  end

  wb_mem_array #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH),
    .SW    (SW)
  ) u_array (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (mem_en_s),
    .we_i   (mem_we_s),
    .sel_i  (sel_i),
    .adr_i  (mem_adr_s),
    .dat_i  (dat_i),
    .dat_o  (dat_o)
  );

  assign ack_o = ack_r;
  assign err_o = err_r;

endmodule
